// File: rtl/debug_pkg.sv
// Shared definitions for the debug-dump sequencer: section indices, FSM states
// and the default UART data width.
package debug_pkg;

  localparam logic [1:0] SEC_PC  = 2'd0;
  localparam logic [1:0] SEC_CLK = 2'd1;
  localparam logic [1:0] SEC_RB  = 2'd2;
  localparam logic [1:0] SEC_DM  = 2'd3;

  localparam int DEFAULT_TX_WIDTH = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_LOAD,
    S_CAPTURE,
    S_SEND,
    S_WAIT,
    S_NEXT,
    S_DONE
  } state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/word_serializer.sv
// Splits one NBITS word into TX_WIDTH-bit bytes, least significant byte first,
// and flags the final byte of the word.
module word_serializer
  import debug_pkg::*;
#(
  parameter int NBITS    = 32,
  parameter int TX_WIDTH = DEFAULT_TX_WIDTH
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic                shift,
  input  logic [NBITS-1:0]    din,
  output logic [TX_WIDTH-1:0] dout,
  output logic                last_byte
);

  localparam int BPW = NBITS / TX_WIDTH;
  localparam int CW  = (BPW > 1) ? $clog2(BPW) : 1;

  logic [NBITS-1:0] sr;
  logic [CW-1:0]    cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr  <= '0;
      cnt <= '0;
    end else if (load) begin
      sr  <= din;
      cnt <= '0;
    end else if (shift) begin
      sr  <= sr >> TX_WIDTH;
      cnt <= cnt + CW'(1);
    end
  end

  assign dout      = sr[TX_WIDTH-1:0];
  assign last_byte = (cnt == CW'(BPW - 1));

endmodule

// File: rtl/debug_dump_ctrl.sv
// Debug-dump sequencer: snapshots PC and cycle count on a start edge, then
// streams the enabled sections (PC, clock count, RB, DM) byte-wise to the UART.
module debug_dump_ctrl
  import debug_pkg::*;
#(
  parameter int NBITS          = 32,
  parameter int RBITS          = 5,
  parameter int BANK_SIZE      = 32,
  parameter int DM_ADDR_LENGTH = 32,
  parameter int DM_MEM_SIZE    = 32,
  parameter int TX_WIDTH       = DEFAULT_TX_WIDTH
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      send_flag,
  input  logic                      abort,
  input  logic [3:0]                section_mask,
  input  logic [NBITS-1:0]          current_pc,
  input  logic [NBITS-1:0]          clock_count,
  input  logic [NBITS-1:0]          RB_Data,
  input  logic [NBITS-1:0]          DM_Data,
  output logic [RBITS-1:0]          RB_Addr,
  output logic [DM_ADDR_LENGTH-1:0] DM_Addr,
  output logic [TX_WIDTH-1:0]       tx_Data,
  output logic                      tx_start,
  input  logic                      tx_done,
  output logic                      send_done,
  output logic                      busy
);

  localparam int BPW  = NBITS / TX_WIDTH;
  localparam int WIDX = $clog2(max_int(max_int(BANK_SIZE, DM_MEM_SIZE), 2));

  state_t                    state, state_nxt;
  logic                      send_flag_q, start;
  logic [3:0]                mask_q;
  logic [NBITS-1:0]          pc_q, clk_q, cap_word;
  logic [1:0]                sec, sel_sec;
  logic [2:0]                from;
  logic                      sel_valid, sel_mem;
  logic [WIDX-1:0]           word_idx, word_inc;
  logic                      last_word, last_byte, load, shift;
  logic [RBITS-1:0]          rb_addr;
  logic [DM_ADDR_LENGTH-1:0] dm_addr;

  // A start edge only counts while idle; the register resets low so a
  // request already high at reset release still starts a dump.
  assign start = send_flag & ~send_flag_q & (state == S_IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      send_flag_q <= 1'b0;
      mask_q      <= '0;
      state       <= S_IDLE;
    end else begin
      send_flag_q <= send_flag;
      if (start) mask_q <= section_mask;
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (start) begin
      pc_q  <= current_pc;
      clk_q <= clock_count;
    end
  end

  // Next enabled section at or after 'from' (the one after the current section in NEXT).
  always_comb begin
    from      = (state == S_NEXT) ? ({1'b0, sec} + 3'd1) : 3'd0;
    sel_valid = 1'b0;
    sel_sec   = SEC_PC;
    for (int i = 3; i >= 0; i--) begin
      if (mask_q[i] && (3'(i) >= from)) begin
        sel_valid = 1'b1;
        sel_sec   = 2'(i);
      end
    end
  end

  assign sel_mem  = (sel_sec == SEC_RB) || (sel_sec == SEC_DM);
  assign word_inc = word_idx + WIDX'(1);

  always_comb begin
    case (sec)
      SEC_RB:  last_word = (word_idx == WIDX'(BANK_SIZE - 1));
      SEC_DM:  last_word = (word_idx == WIDX'(DM_MEM_SIZE - 1));
      default: last_word = 1'b1;
    endcase
  end

  always_comb begin
    case (sec)
      SEC_PC:  cap_word = pc_q;
      SEC_CLK: cap_word = clk_q;
      SEC_RB:  cap_word = RB_Data;
      default: cap_word = DM_Data;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sec      <= SEC_PC;
      word_idx <= '0;
      rb_addr  <= '0;
      dm_addr  <= '0;
    end else if (sel_valid && ((state == S_SELECT) ||
                               (state == S_NEXT && last_byte && last_word))) begin
      sec      <= sel_sec;
      word_idx <= '0;
      if (sel_sec == SEC_RB) rb_addr <= '0;
      if (sel_sec == SEC_DM) dm_addr <= '0;
    end else if (state == S_NEXT && last_byte && !last_word) begin
      word_idx <= word_inc;
      if (sec == SEC_RB) rb_addr <= RBITS'(word_inc);
      if (sec == SEC_DM) dm_addr <= DM_ADDR_LENGTH'(word_inc) * DM_ADDR_LENGTH'(BPW);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (start) state_nxt = S_SELECT;
      S_SELECT:  state_nxt = !sel_valid ? S_DONE : (sel_mem ? S_LOAD : S_CAPTURE);
      S_LOAD:    state_nxt = S_CAPTURE;
      S_CAPTURE: state_nxt = S_SEND;
      S_SEND:    state_nxt = S_WAIT;
      S_WAIT:    if (tx_done) state_nxt = S_NEXT;
      S_NEXT: begin
        if (!last_byte)      state_nxt = S_SEND;
        else if (!last_word) state_nxt = S_LOAD;
        else if (!sel_valid) state_nxt = S_DONE;
        else                 state_nxt = sel_mem ? S_LOAD : S_CAPTURE;
      end
      S_DONE:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
    if (abort && (state != S_IDLE)) state_nxt = S_IDLE;
  end

  always_comb begin
    tx_start  = (state == S_SEND);
    send_done = (state == S_DONE);
    busy      = (state != S_IDLE);
    load      = (state == S_CAPTURE);
    shift     = (state == S_NEXT) && !last_byte;
  end

  assign RB_Addr = rb_addr;
  assign DM_Addr = dm_addr;

  word_serializer #(
    .NBITS    (NBITS),
    .TX_WIDTH (TX_WIDTH)
  ) u_ser (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .shift     (shift),
    .din       (cap_word),
    .dout      (tx_Data),
    .last_byte (last_byte)
  );

endmodule

// File: tb/tb_debug_dump_ctrl.sv
// Directed bench for debug_dump_ctrl with a small RB/DM memory and a UART model
// that answers every tx_start with tx_done three cycles later.
module tb_debug_dump_ctrl;

  typedef logic [7:0]  bq_t[$];
  typedef logic [31:0] wq_t[$];

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        send_flag = 1'b0;
  logic        abort = 1'b0;
  logic [3:0]  section_mask = 4'h0;
  logic [31:0] current_pc = 32'h0;
  logic [31:0] clock_count = 32'h0;
  logic [31:0] RB_Data = 32'h0;
  logic [31:0] DM_Data = 32'h0;
  logic [4:0]  RB_Addr;
  logic [31:0] DM_Addr;
  logic [7:0]  tx_Data;
  logic        tx_start;
  logic        tx_done = 1'b0;
  logic        send_done;
  logic        busy;

  debug_dump_ctrl #(
    .NBITS(32), .RBITS(5), .BANK_SIZE(2), .DM_ADDR_LENGTH(32),
    .DM_MEM_SIZE(2), .TX_WIDTH(8)
  ) dut (
    .clk(clk), .reset(reset), .send_flag(send_flag), .abort(abort),
    .section_mask(section_mask), .current_pc(current_pc),
    .clock_count(clock_count), .RB_Data(RB_Data), .DM_Data(DM_Data),
    .RB_Addr(RB_Addr), .DM_Addr(DM_Addr), .tx_Data(tx_Data),
    .tx_start(tx_start), .tx_done(tx_done), .send_done(send_done), .busy(busy)
  );

  always #5 clk = ~clk;

  int          cyc = 0;
  int          ucnt = 0;
  logic [31:0] rb_mem [0:31];
  logic [31:0] dm_mem [0:1];

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    RB_Data <= rb_mem[RB_Addr];
    DM_Data <= dm_mem[DM_Addr[2]];
    if (!reset) begin
      ucnt    <= 0;
      tx_done <= 1'b0;
    end else begin
      tx_done <= (ucnt == 1);
      if (tx_start)      ucnt <= 2;
      else if (ucnt > 0) ucnt <= ucnt - 1;
    end
  end

  logic [7:0]  byte_q[$];
  logic [4:0]  rba_q[$];
  logic [31:0] dma_q[$];
  int          start_q[$];
  int          done_cnt = 0;
  int          done_cyc = 0;
  int          txd_cyc = 0;
  int          edge_cyc = 0;

  always @(negedge clk) begin
    if (tx_start) begin
      byte_q.push_back(tx_Data);
      rba_q.push_back(RB_Addr);
      dma_q.push_back(DM_Addr);
      start_q.push_back(cyc);
    end
    if (send_done) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
    if (tx_done) txd_cyc = cyc;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_log();
    byte_q.delete();
    rba_q.delete();
    dma_q.delete();
    start_q.delete();
  endtask

  function automatic bq_t to_bytes(input wq_t w);
    bq_t b;
    for (int i = 0; i < w.size(); i++)
      for (int k = 0; k < 4; k++) b.push_back(8'((w[i] >> (8 * k)) & 32'hFF));
    return b;
  endfunction

  task automatic check_bytes(input string tag, input bq_t exp);
    check({tag, "_count"}, 64'(byte_q.size()), 64'(exp.size()));
    for (int i = 0; i < exp.size(); i++)
      if (i < byte_q.size()) check($sformatf("%s_b%0d", tag, i), 64'(byte_q[i]), 64'(exp[i]));
  endtask

  task automatic start_dump(input logic [3:0] m);
    tick();
    section_mask = m;
    send_flag    = 1'b1;
    edge_cyc     = cyc;
    clear_log();
    tick();
    send_flag = 1'b0;
    check("busy_rise", 64'(busy), 64'd1);
  endtask

  task automatic wait_done(input string tag);
    int prev = done_cnt;
    int n = 0;
    while (done_cnt == prev && n < 1000) begin
      tick();
      n++;
    end
    check({tag, "_done_seen"}, 64'(done_cnt - prev), 64'd1);
    tick();
    check({tag, "_busy_fall"}, 64'(busy), 64'd0);
  endtask

  task automatic wait_starts(input int cnt);
    int n = 0;
    while (start_q.size() < cnt && n < 1000) begin
      tick();
      n++;
    end
    check("tx_start_reached", 64'(start_q.size() >= cnt), 64'd1);
  endtask

  initial begin
    bq_t full_exp;
    int  base;
    full_exp = to_bytes('{32'h02, 32'h03, 32'h45, 32'h45, 32'h7F, 32'h7F});
    for (int i = 0; i < 32; i++) rb_mem[i] = 32'h0;
    rb_mem[0] = 32'h45; rb_mem[1] = 32'h45;
    dm_mem[0] = 32'h7F; dm_mem[1] = 32'h7F;
    current_pc  = 32'h02;
    clock_count = 32'h03;

    // reset state
    repeat (3) tick();
    check("rst_tx_start", 64'(tx_start), 64'd0);
    check("rst_send_done", 64'(send_done), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_tx_data", 64'(tx_Data), 64'd0);
    check("rst_rb_addr", 64'(RB_Addr), 64'd0);
    check("rst_dm_addr", 64'(DM_Addr), 64'd0);
    reset = 1'b1;
    repeat (2) tick();

    // full dump
    start_dump(4'hF);
    wait_done("full");
    check_bytes("full", full_exp);
    check("full_done_gap", 64'(done_cyc - txd_cyc), 64'd2);
    if (start_q.size() >= 24) begin
      check("full_first_lat", 64'(start_q[0] - edge_cyc), 64'd3);
      check("full_gap_byte", 64'(start_q[1] - start_q[0]), 64'd5);
      check("full_gap_snap", 64'(start_q[4] - start_q[3]), 64'd6);
      check("full_gap_mem", 64'(start_q[8] - start_q[7]), 64'd7);
      for (int i = 16; i < 24; i++)
        check($sformatf("full_dm_addr%0d", i), 64'(dma_q[i]), 64'(((i - 16) / 4) * 4));
    end

    // register bank only
    rb_mem[0] = 32'h11223344; rb_mem[1] = 32'hAABBCCDD;
    start_dump(4'b0100);
    wait_done("rb");
    check_bytes("rb", '{8'h44, 8'h33, 8'h22, 8'h11, 8'hDD, 8'hCC, 8'hBB, 8'hAA});
    if (start_q.size() >= 8) begin
      check("rb_first_lat", 64'(start_q[0] - edge_cyc), 64'd4);
      check("rb_gap_word", 64'(start_q[4] - start_q[3]), 64'd7);
      for (int i = 0; i < 8; i++)
        check($sformatf("rb_addr%0d", i), 64'(rba_q[i]), 64'(i / 4));
    end
    rb_mem[0] = 32'h45; rb_mem[1] = 32'h45;

    // empty mask
    start_dump(4'h0);
    wait_done("empty");
    check("empty_done_lat", 64'(done_cyc - edge_cyc), 64'd2);
    check("empty_no_bytes", 64'(byte_q.size()), 64'd0);

    // abort in the 6th WAIT, then restart
    base = done_cnt;
    start_dump(4'hF);
    wait_starts(6);
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_tx_start", 64'(tx_start), 64'd0);
    repeat (20) tick();
    check("abort_no_done", 64'(done_cnt - base), 64'd0);
    check_bytes("abort", '{8'h02, 8'h00, 8'h00, 8'h00, 8'h03, 8'h00});
    start_dump(4'hF);
    wait_done("restart");
    check_bytes("restart", full_exp);
    if (start_q.size() > 0) check("restart_lat", 64'(start_q[0] - edge_cyc), 64'd3);

    // snapshot isolation and retrigger while busy
    base = done_cnt;
    start_dump(4'b0011);
    tick();
    current_pc = 32'h99;
    send_flag  = 1'b1;
    tick();
    send_flag = 1'b0;
    tick();
    send_flag = 1'b1;
    tick();
    send_flag = 1'b0;
    wait_done("snap");
    repeat (30) tick();
    check_bytes("snap", '{8'h02, 8'h00, 8'h00, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00});
    check("snap_one_dump", 64'(done_cnt - base), 64'd1);
    current_pc = 32'h02;

    // asynchronous reset during SEND, restart from send_flag held high
    start_dump(4'hF);
    wait_starts(1);
    check("pre_rst_tx_start", 64'(tx_start), 64'd1);
    reset     = 1'b0;
    send_flag = 1'b1;
    #1;
    check("arst_tx_start", 64'(tx_start), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_tx_data", 64'(tx_Data), 64'd0);
    clear_log();
    tick();
    reset    = 1'b1;
    edge_cyc = cyc;
    tick();
    check("arst_restart_busy", 64'(busy), 64'd1);
    send_flag = 1'b0;
    wait_done("arst");
    check_bytes("arst", full_exp);
    if (start_q.size() > 0) check("arst_lat", 64'(start_q[0] - edge_cyc), 64'd3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/debug_dump_ctrl.md
# debug_dump_ctrl

Parametrised debug-dump sequencer, the next generation of `send_control`. On a start request it snapshots the processor's PC and clock counter, then walks a selectable set of sections (PC, clock count, register bank, data memory). Each word is serialised into 8-bit bytes, LSB first, for the UART transmitter. It sits between the debug unit's command decoder, the datapath read ports (register bank, data memory) and the UART TX.

## Interface
Parameters:
- `NBITS`, 32, word width of PC / clock count / RB / DM data; multiple of 8
- `RBITS`, 5, register-bank address width
- `BANK_SIZE`, 32, registers dumped (indices 0..BANK_SIZE-1)
- `DM_ADDR_LENGTH`, 32, data-memory byte-address width
- `DM_MEM_SIZE`, 32, data-memory words dumped
- `TX_WIDTH`, 8, UART data width; NBITS/TX_WIDTH = bytes per word (BPW)

Ports:
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-low
- `send_flag`  in  1  start request; rising edge starts a dump
- `abort`  in  1  synchronous cancel
- `section_mask`  in  4  bit0 PC, bit1 clock_count, bit2 RB, bit3 DM; sampled at start
- `current_pc`  in  NBITS  PC value
- `clock_count`  in  NBITS  cycle counter value
- `RB_Data`  in  NBITS  register-bank read data, valid 1 cycle after `RB_Addr`
- `DM_Data`  in  NBITS  data-memory read data, valid 1 cycle after `DM_Addr`
- `RB_Addr`  out  RBITS  register index being read
- `DM_Addr`  out  DM_ADDR_LENGTH  byte address = word_index*BPW
- `tx_Data`  out  TX_WIDTH  byte to transmit
- `tx_start`  out  1  one-cycle pulse, `tx_Data` valid
- `tx_done`  in  1  UART finished current byte
- `send_done`  out  1  one-cycle pulse, dump complete
- `busy`  out  1  high from start-edge cycle+1 until return to IDLE

## Operation
- Edge detector: the `send_flag_q` register resets to 0, so `send_flag` high at reset release counts as an edge. Edges are ignored while busy.
- On start: latch `section_mask`, `current_pc` and `clock_count` into snapshot registers. Later changes to these inputs do not affect the dump.
- Fixed order: PC, clock_count, RB[0..BANK_SIZE-1], DM words 0..DM_MEM_SIZE-1. Disabled sections are skipped entirely.
- FSM states:
  - IDLE
  - SELECT: pick the next enabled section or go to DONE.
  - LOAD: drive `RB_Addr`/`DM_Addr`, one wait cycle. Snapshots skip LOAD.
  - CAPTURE: latch the word into the serializer.
  - SEND: `tx_start`=1 for one cycle, `tx_Data` = current byte.
  - WAIT: hold until `tx_done`=1.
  - NEXT: advance byte, then word, then section.
  - DONE: `send_done`=1, go to IDLE.
- Byte order: byte k = word[8k+7:8k], k = 0..BPW-1.
- Total bytes = BPW*(m0 + m1 + m2*BANK_SIZE + m3*DM_MEM_SIZE).
- `section_mask` = 0: SELECT goes straight to DONE. No `tx_start`; `send_done` pulses.
- `abort`=1 in any non-IDLE state: IDLE next cycle, with `tx_start`=0, no `send_done`, and `busy`=0. `abort` in IDLE has no effect.
- Counters: word index width is clog2(max(BANK_SIZE, DM_MEM_SIZE)). The byte counter wraps at BPW-1 and the word counter at SIZE-1; each wrap advances to the next section.

## Timing
- Reset values: `tx_start` 0, `send_done` 0, `busy` 0, `tx_Data` 0, `RB_Addr` 0, `DM_Addr` 0, FSM in IDLE.
- Edge in cycle t: `busy`=1 at t+1.
  - First `tx_start` at t+3 when PC is enabled (SELECT, CAPTURE, SEND).
  - First `tx_start` at t+4 for RB/DM (adds LOAD).
- `tx_done` counts only in WAIT. A `tx_done` coinciding with `tx_start` is ignored.
- After `tx_done` in WAIT at cycle u:
  - Next byte of the same word: `tx_start` at u+2.
  - New snapshot word: `tx_start` at u+3.
  - New memory word: `tx_start` at u+4.
- `tx_Data` holds stable from SEND until the next CAPTURE/NEXT update.
- Final `tx_done` at u: `send_done` at u+2 (NEXT, then DONE); `busy` low at u+3.
- `send_flag` held high through DONE does not retrigger; a new 0→1 edge is required.
- Reset asserted mid-dump: all outputs return to reset values immediately (asynchronous).

## Structure
- Shared `debug_pkg`: section bit indices (SEC_PC=0, SEC_CLK=1, SEC_RB=2, SEC_DM=3), FSM state enum, default `TX_WIDTH`.
- Sub-module `word_serializer`: NBITS shift register with load, shift-by-TX_WIDTH, byte counter, and a `last_byte` flag.
- Top: edge detector, snapshot registers, FSM, section/word counters, address generation.

## Test plan
Bench parameters: NBITS=32, BANK_SIZE=2, DM_MEM_SIZE=2. UART model pulses `tx_done` 3 cycles after each `tx_start`.

- Mask 4'hF, PC=0x02, clk=0x03, RB=0x45, DM=0x7F → 24 bytes: 02 00 00 00, 03 00 00 00, 45 00 00 00 ×2, 7F 00 00 00 ×2. `send_done` once, 2 cycles after the last `tx_done`. `DM_Addr` goes 0 then 4.
- Mask 4'b0100, RB[0]=0x11223344, RB[1]=0xAABBCCDD → bytes 44 33 22 11 DD CC BB AA. `RB_Addr` 0 then 1. No PC/DM bytes.
- Mask 0 → no `tx_start`; `send_done` pulse 2 cycles after the edge.
- `abort` during the 6th WAIT → IDLE next cycle, no `send_done`. A new edge restarts from PC byte 0.
- `current_pc` changed 0x02→0x99 mid-dump, plus `send_flag` re-pulsed while busy → PC bytes remain 02 00 00 00 and only one dump occurs.
- Reset pulled low during SEND → `tx_start`, `busy` and `tx_Data` go to 0 immediately. After release with `send_flag`=1, a dump starts.
